trap_ctrl: RTL and testbench

Parametrised machine-mode trap controller for the five-stage RV32 core, the successor to the single-interrupt exception unit. It owns the M-mode CSR file, accepts `NUM_IRQ` level-sensitive interrupt lines with an enable/pending mask, and prioritises synchronous exceptions over interrupts. It supports direct or vectored `mtvec`, captures `mtval`, and produces the PC redirect plus pipeline flush controls. It sits beside the MEM stage: exception flags, `epc_cur` and `epc_next` come from EX/MEM, and the redirect goes to the IF PC mux.

---
 rtl/trap_pkg.sv | 48 ++++
 rtl/trap_csr_file.sv | 137 +++++++++++++
 rtl/trap_ctrl.sv | 179 +++++++++++++++++
 tb/tb_trap_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_pkg.sv
// trap_pkg
// Shared definitions for the machine-mode trap controller: CSR addresses,
// trap cause codes, CSR write/set/clear encodings, controller FSM states and
// the CSR read-modify-write helper.
package trap_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;

  localparam logic [1:0] WSC_READ  = 2'b00;
  localparam logic [1:0] WSC_WRITE = 2'b01;
  localparam logic [1:0] WSC_SET   = 2'b10;
  localparam logic [1:0] WSC_CLEAR = 2'b11;

  localparam logic [31:0] CAUSE_ILLEGAL     = 32'd2;
  localparam logic [31:0] CAUSE_ECALL_M     = 32'd11;
  localparam logic [31:0] CAUSE_LOAD_FAULT  = 32'd5;
  localparam logic [31:0] CAUSE_STORE_FAULT = 32'd7;
  localparam logic [31:0] CAUSE_IRQ_FLAG    = 32'h8000_0000;
  // External line i maps to interrupt cause / mip / mie bit 16+i.
  localparam logic [31:0] IRQ_CAUSE_BASE    = 32'd16;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SETTLE = 1'b1
  } trap_state_e;

  // New CSR value for a write/set/clear, computed from the current read value.
  function automatic logic [31:0] wsc_apply(input logic [1:0]  mode,
                                            input logic [31:0] old_val,
                                            input logic [31:0] wdata);
    logic [31:0] res;
    case (mode)
      WSC_WRITE: res = wdata;
      WSC_SET:   res = old_val | wdata;
      WSC_CLEAR: res = old_val & ~wdata;
      default:   res = old_val;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/trap_csr_file.sv
// trap_csr_file
// The eight machine-mode CSRs with their field masking, the combinational
// read mux and the write/set/clear path. Trap entry and mret are applied as
// strobes; the caller has already resolved precedence, so at most one of
// i_trap / i_mret / i_csr_we is meaningful in a cycle (checked in that order).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   i_csr_we            commit a CSR write/set/clear this edge
//   i_csr_mode          write/set/clear encoding
//   i_csr_addr          CSR address (also drives the read mux)
//   i_csr_wdata         write operand
//   o_csr_rdata         combinational read data
//   i_mip_irq           sampled interrupt lines (mip source)
//   i_trap              trap entry strobe with i_trap_epc/cause/tval
//   i_mret              mret strobe
//   o_mstatus_mie       mstatus.MIE
//   o_mie_mask          mie enable bits, one per line
//   o_mtvec, o_mepc     trap vector and exception PC as read
module trap_csr_file
  import trap_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_IRQ  = 4,
  parameter int VECTORED = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_csr_we,
  input  logic [1:0]         i_csr_mode,
  input  logic [11:0]        i_csr_addr,
  input  logic [XLEN-1:0]    i_csr_wdata,
  output logic [XLEN-1:0]    o_csr_rdata,
  input  logic [NUM_IRQ-1:0] i_mip_irq,
  input  logic               i_trap,
  input  logic [XLEN-1:0]    i_trap_epc,
  input  logic [XLEN-1:0]    i_trap_cause,
  input  logic [XLEN-1:0]    i_trap_tval,
  input  logic               i_mret,
  output logic               o_mstatus_mie,
  output logic [NUM_IRQ-1:0] o_mie_mask,
  output logic [XLEN-1:0]    o_mtvec,
  output logic [XLEN-1:0]    o_mepc
);

  logic               r_mstatus_mie;
  logic               r_mstatus_mpie;
  logic [NUM_IRQ-1:0] r_mie;
  logic [XLEN-1:2]    r_mtvec_base;
  logic [1:0]         r_mtvec_mode;
  logic [XLEN-1:0]    r_mscratch;
  logic [XLEN-1:2]    r_mepc;
  logic [XLEN-1:0]    r_mcause;
  logic [XLEN-1:0]    r_mtval;

  logic [XLEN-1:0]    w_mstatus;
  logic [XLEN-1:0]    w_mie_word;
  logic [XLEN-1:0]    w_mip_word;
  logic [XLEN-1:0]    w_rdata;
  logic [XLEN-1:0]    w_wval;

  // Architectural views of the packed fields; MPP is hardwired to M-mode.
  always_comb begin
    w_mstatus        = '0;
    w_mstatus[12:11] = 2'b11;
    w_mstatus[7]     = r_mstatus_mpie;
    w_mstatus[3]     = r_mstatus_mie;
    w_mie_word       = '0;
    w_mie_word[16 +: NUM_IRQ] = r_mie;
    w_mip_word       = '0;
    w_mip_word[16 +: NUM_IRQ] = i_mip_irq;
  end

  always_comb begin
    case (i_csr_addr)
      CSR_MSTATUS:  w_rdata = w_mstatus;
      CSR_MIE:      w_rdata = w_mie_word;
      CSR_MTVEC:    w_rdata = {r_mtvec_base, r_mtvec_mode};
      CSR_MSCRATCH: w_rdata = r_mscratch;
      CSR_MEPC:     w_rdata = {r_mepc, 2'b00};
      CSR_MCAUSE:   w_rdata = r_mcause;
      CSR_MTVAL:    w_rdata = r_mtval;
      CSR_MIP:      w_rdata = w_mip_word;
      default:      w_rdata = '0;
    endcase
  end

  // Set/clear operate on the masked read value, so unimplemented bits stay 0.
  assign w_wval = wsc_apply(i_csr_mode, w_rdata, i_csr_wdata);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_mie          <= '0;
      r_mtvec_base   <= '0;
      r_mtvec_mode   <= 2'b00;
      r_mscratch     <= '0;
      r_mepc         <= '0;
      r_mcause       <= '0;
      r_mtval        <= '0;
    end else if (i_trap) begin
      r_mepc         <= i_trap_epc[XLEN-1:2];
      r_mcause       <= i_trap_cause;
      r_mtval        <= i_trap_tval;
      r_mstatus_mpie <= r_mstatus_mie;
      r_mstatus_mie  <= 1'b0;
    end else if (i_mret) begin
      r_mstatus_mie  <= r_mstatus_mpie;
      r_mstatus_mpie <= 1'b1;
    end else if (i_csr_we) begin
      case (i_csr_addr)
        CSR_MSTATUS: begin
          r_mstatus_mie  <= w_wval[3];
          r_mstatus_mpie <= w_wval[7];
        end
        CSR_MIE:      r_mie <= w_wval[16 +: NUM_IRQ];
        CSR_MTVEC: begin
          r_mtvec_base <= w_wval[XLEN-1:2];
          // WARL: only vectored mode survives, and only when built in.
          r_mtvec_mode <= ((VECTORED != 0) && (w_wval[1:0] == 2'b01)) ? 2'b01 : 2'b00;
        end
        CSR_MSCRATCH: r_mscratch <= w_wval;
        CSR_MEPC:     r_mepc     <= w_wval[XLEN-1:2];
        CSR_MCAUSE:   r_mcause   <= w_wval;
        CSR_MTVAL:    r_mtval    <= w_wval;
        default: ;
      endcase
    end
  end

  assign o_csr_rdata   = w_rdata;
  assign o_mstatus_mie = r_mstatus_mie;
  assign o_mie_mask    = r_mie;
  assign o_mtvec       = {r_mtvec_base, r_mtvec_mode};
  assign o_mepc        = {r_mepc, 2'b00};

endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl
// Machine-mode trap controller beside the MEM stage. Prioritises synchronous
// exceptions over interrupts, samples the level interrupt lines, sequences
// RUN/SETTLE and drives the PC redirect and pipeline flushes
// combinationally from the same-cycle inputs.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   csr_rw/csr_wsc_mode/csr_addr/csr_wdata/csr_rdata   CSR access from MEM
//   irq                           level interrupt requests
//   illegal_inst, ecall_m, l_access_fault, s_access_fault   exception flags
//   inst_word, fault_addr         mtval sources
//   mret                          MRET in MEM
//   epc_cur, epc_next             PC of MEM instruction and its successor
//   pc_redirect, redirect_valid   redirect to the IF PC mux
//   flush_fd/de/em/mw, regwrite_cancel   pipeline kill controls
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_IRQ  = 4,
  parameter int VECTORED = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               csr_rw,
  input  logic [1:0]         csr_wsc_mode,
  input  logic [11:0]        csr_addr,
  input  logic [XLEN-1:0]    csr_wdata,
  output logic [XLEN-1:0]    csr_rdata,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               illegal_inst,
  input  logic               ecall_m,
  input  logic               l_access_fault,
  input  logic               s_access_fault,
  input  logic [31:0]        inst_word,
  input  logic [XLEN-1:0]    fault_addr,
  input  logic               mret,
  input  logic [XLEN-1:0]    epc_cur,
  input  logic [XLEN-1:0]    epc_next,
  output logic [XLEN-1:0]    pc_redirect,
  output logic               redirect_valid,
  output logic               flush_fd,
  output logic               flush_de,
  output logic               flush_em,
  output logic               flush_mw,
  output logic               regwrite_cancel
);

  trap_state_e        r_state;
  trap_state_e        w_state_nxt;
  logic [NUM_IRQ-1:0] r_irq_smp;

  logic               w_mstatus_mie;
  logic [NUM_IRQ-1:0] w_mie_mask;
  logic [XLEN-1:0]    w_mtvec;
  logic [XLEN-1:0]    w_mepc;
  logic [XLEN-1:0]    w_base;

  logic               w_exc;
  logic               w_exc_take;
  logic [NUM_IRQ-1:0] w_irq_act;
  logic [4:0]         w_irq_idx;
  logic               w_irq_take;
  logic               w_trap;
  logic               w_mret_take;
  logic               w_csr_we;
  logic [XLEN-1:0]    w_cause;
  logic [XLEN-1:0]    w_tval;
  logic               w_unused_epc_next;

  // Traps always resume at the faulting/interrupted instruction via epc_cur.
  assign w_unused_epc_next = ^epc_next;

  assign w_exc      = illegal_inst | ecall_m | l_access_fault | s_access_fault;
  assign w_irq_act  = r_irq_smp & w_mie_mask;
  // Reset gates every action so nothing commits or redirects during rst.
  assign w_exc_take = !rst && w_exc;
  assign w_irq_take = !rst && !w_exc && w_mstatus_mie && (|w_irq_act)
                      && (r_state == ST_RUN);
  assign w_trap      = w_exc_take | w_irq_take;
  assign w_mret_take = !rst && mret && !w_trap;
  assign w_csr_we    = !rst && csr_rw && (csr_wsc_mode != WSC_READ)
                       && !w_trap && !mret;

  // Lowest pending enabled line wins.
  always_comb begin
    w_irq_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_irq_act[i]) w_irq_idx = 5'(i);
    end
  end

  always_comb begin
    w_cause = '0;
    w_tval  = '0;
    if (illegal_inst) begin
      w_cause = CAUSE_ILLEGAL;
      w_tval  = inst_word;
    end else if (ecall_m) begin
      w_cause = CAUSE_ECALL_M;
    end else if (l_access_fault) begin
      w_cause = CAUSE_LOAD_FAULT;
      w_tval  = fault_addr;
    end else if (s_access_fault) begin
      w_cause = CAUSE_STORE_FAULT;
      w_tval  = fault_addr;
    end else begin
      w_cause = CAUSE_IRQ_FLAG | (IRQ_CAUSE_BASE + {27'b0, w_irq_idx});
    end
  end

  assign w_base = {w_mtvec[XLEN-1:2], 2'b00};

  always_comb begin
    redirect_valid  = 1'b0;
    pc_redirect     = '0;
    regwrite_cancel = 1'b0;
    if (w_trap) begin
      redirect_valid  = 1'b1;
      regwrite_cancel = 1'b1;
      pc_redirect     = w_base;
      if (!w_exc_take && (w_mtvec[1:0] == 2'b01))
        pc_redirect = w_base + ((IRQ_CAUSE_BASE + {27'b0, w_irq_idx}) << 2);
    end else if (w_mret_take) begin
      redirect_valid = 1'b1;
      pc_redirect    = w_mepc;
    end
  end

  assign flush_fd = redirect_valid;
  assign flush_de = redirect_valid;
  assign flush_em = redirect_valid;
  assign flush_mw = redirect_valid;

  always_ff @(posedge clk) begin
    if (rst) r_irq_smp <= '0;
    else     r_irq_smp <= irq;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_state_nxt;
  end

  // SETTLE masks interrupts for one cycle after any redirect.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:    if (w_trap || w_mret_take) w_state_nxt = ST_SETTLE;
      ST_SETTLE: w_state_nxt = ST_RUN;
      default:   w_state_nxt = ST_RUN;
    endcase
  end

  trap_csr_file #(
    .XLEN     (XLEN),
    .NUM_IRQ  (NUM_IRQ),
    .VECTORED (VECTORED)
  ) u_csr (
    .clk           (clk),
    .rst           (rst),
    .i_csr_we      (w_csr_we),
    .i_csr_mode    (csr_wsc_mode),
    .i_csr_addr    (csr_addr),
    .i_csr_wdata   (csr_wdata),
    .o_csr_rdata   (csr_rdata),
    .i_mip_irq     (r_irq_smp),
    .i_trap        (w_trap),
    .i_trap_epc    (epc_cur),
    .i_trap_cause  (w_cause),
    .i_trap_tval   (w_tval),
    .i_mret        (w_mret_take),
    .o_mstatus_mie (w_mstatus_mie),
    .o_mie_mask    (w_mie_mask),
    .o_mtvec       (w_mtvec),
    .o_mepc        (w_mepc)
  );

endmodule

// File: tb/tb_trap_ctrl.sv
module tb_trap_ctrl;

  localparam int NIRQ = 4;
  localparam logic [31:0] MIE_MASK = ((32'd1 << NIRQ) - 32'd1) << 16;

  logic        clk = 1'b0;
  logic        rst, csr_rw, mret;
  logic [1:0]  csr_wsc_mode;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, csr_rdata, inst_word, fault_addr, epc_cur, epc_next, pc_redirect;
  logic [NIRQ-1:0] irq;
  logic illegal_inst, ecall_m, l_access_fault, s_access_fault;
  logic redirect_valid, flush_fd, flush_de, flush_em, flush_mw, regwrite_cancel;

  trap_ctrl #(.XLEN(32), .NUM_IRQ(NIRQ), .VECTORED(1)) dut (
    .clk(clk), .rst(rst), .csr_rw(csr_rw), .csr_wsc_mode(csr_wsc_mode),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .irq(irq),
    .illegal_inst(illegal_inst), .ecall_m(ecall_m), .l_access_fault(l_access_fault),
    .s_access_fault(s_access_fault), .inst_word(inst_word), .fault_addr(fault_addr),
    .mret(mret), .epc_cur(epc_cur), .epc_next(epc_next), .pc_redirect(pc_redirect),
    .redirect_valid(redirect_valid), .flush_fd(flush_fd), .flush_de(flush_de),
    .flush_em(flush_em), .flush_mw(flush_mw), .regwrite_cancel(regwrite_cancel)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference machine state: architectural CSR words as software sees them.
  logic [31:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
  logic [NIRQ-1:0] m_pend;
  bit          m_settle;

  // Per-cycle decision: 0 none, 1 exception, 2 interrupt, 3 mret.
  int          e_kind, e_irq;
  logic [31:0] e_code, e_tval, e_pc, e_rdata;
  logic        e_valid, e_cancel;
  logic [31:0] last_pc, last_rdata;
  logic        last_valid, last_cancel;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return m_mstatus;
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'h344: return 32'(m_pend) << 16;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_mstatus = 32'h1800; m_mie = 0; m_mtvec = 0; m_mscratch = 0;
    m_mepc = 0; m_mcause = 0; m_mtval = 0; m_pend = '0; m_settle = 0;
  endtask

  task automatic model_eval();
    logic flags [4];
    logic [31:0] codes [4];
    flags[0] = illegal_inst; flags[1] = ecall_m; flags[2] = l_access_fault; flags[3] = s_access_fault;
    codes[0] = 32'd2; codes[1] = 32'd11; codes[2] = 32'd5; codes[3] = 32'd7;
    e_kind = 0; e_irq = 0; e_code = 0; e_tval = 0;
    if (!rst) begin
      for (int k = 0; k < 4; k++)
        if (flags[k] && e_kind == 0) begin
          e_kind = 1; e_code = codes[k];
          e_tval = (k == 0) ? inst_word : (k == 1) ? 32'h0 : fault_addr;
        end
      if (e_kind == 0 && m_mstatus[3] && !m_settle)
        for (int i = 0; i < NIRQ; i++)
          if (e_kind == 0 && m_pend[i] && m_mie[16+i]) begin
            e_kind = 2; e_irq = i; e_code = 32'h8000_0000 + 32'(16 + i);
          end
      if (e_kind == 0 && mret) e_kind = 3;
    end
    e_valid  = (e_kind != 0);
    e_cancel = (e_kind == 1 || e_kind == 2);
    case (e_kind)
      1: e_pc = m_mtvec & ~32'h3;
      2: e_pc = (m_mtvec & ~32'h3) + ((m_mtvec[1:0] == 2'b01) ? 32'(4 * (16 + e_irq)) : 32'h0);
      3: e_pc = m_mepc;
      default: e_pc = 32'h0;
    endcase
    e_rdata = m_read(csr_addr);
  endtask

  task automatic model_commit();
    logic [31:0] old_v, nv;
    if (rst) begin
      model_reset();
    end else begin
      if (e_kind == 1 || e_kind == 2) begin
        m_mepc = epc_cur & ~32'h3; m_mcause = e_code; m_mtval = e_tval;
        m_mstatus = 32'h1800 | (m_mstatus[3] ? 32'h80 : 32'h0);
      end else if (e_kind == 3) begin
        m_mstatus = 32'h1880 | (m_mstatus[7] ? 32'h8 : 32'h0);
      end else if (csr_rw && csr_wsc_mode != 2'b00) begin
        old_v = m_read(csr_addr);
        nv = (csr_wsc_mode == 2'b01) ? csr_wdata :
             (csr_wsc_mode == 2'b10) ? (old_v | csr_wdata) : (old_v & ~csr_wdata);
        case (csr_addr)
          12'h300: m_mstatus  = (nv & 32'h88) | 32'h1800;
          12'h304: m_mie      = nv & MIE_MASK;
          12'h305: m_mtvec    = (nv & ~32'h3) | ((nv[1:0] == 2'b01) ? 32'h1 : 32'h0);
          12'h340: m_mscratch = nv;
          12'h341: m_mepc     = nv & ~32'h3;
          12'h342: m_mcause   = nv;
          12'h343: m_mtval    = nv;
          default: ;
        endcase
      end
      m_settle = (e_kind != 0) && !m_settle;
      m_pend = irq;
    end
  endtask

  // One cycle: inputs already driven after a falling edge; compare, then commit.
  task automatic tick();
    #2;
    model_eval();
    last_pc = pc_redirect; last_valid = redirect_valid;
    last_cancel = regwrite_cancel; last_rdata = csr_rdata;
    chk("redirect_valid", 32'(redirect_valid), 32'(e_valid));
    chk("pc_redirect", pc_redirect, e_pc);
    chk("flushes", 32'({flush_fd, flush_de, flush_em, flush_mw}), 32'({4{e_valid}}));
    chk("regwrite_cancel", 32'(regwrite_cancel), 32'(e_cancel));
    chk("csr_rdata", csr_rdata, e_rdata);
    @(posedge clk);
    model_commit();
    @(negedge clk);
  endtask

  task automatic clear_in();
    rst = 0; csr_rw = 0; csr_wsc_mode = 0; csr_addr = 0; csr_wdata = 0;
    illegal_inst = 0; ecall_m = 0; l_access_fault = 0; s_access_fault = 0;
    inst_word = 0; fault_addr = 0; mret = 0; epc_cur = 0; epc_next = 4;
  endtask

  task automatic csr_op(input logic [1:0] mode, input logic [11:0] a, input logic [31:0] d);
    clear_in(); csr_rw = 1; csr_wsc_mode = mode; csr_addr = a; csr_wdata = d;
    tick();
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
    clear_in(); csr_addr = a;
    tick();
    chk(tag, last_rdata, exp);
  endtask

  task automatic do_mret();
    clear_in(); mret = 1; tick();
  endtask

  logic [11:0] addrs [9];

  initial begin
    addrs[0] = 12'h300; addrs[1] = 12'h304; addrs[2] = 12'h305; addrs[3] = 12'h340;
    addrs[4] = 12'h341; addrs[5] = 12'h342; addrs[6] = 12'h343; addrs[7] = 12'h344;
    addrs[8] = 12'h7C0;
    clear_in(); irq = '0; rst = 1;
    @(negedge clk); @(negedge clk);
    model_reset();
    rst = 1; tick();
    chk("rst_valid", 32'(last_valid), 32'h0);
    rd_chk("rst_mstatus", 12'h300, 32'h0000_1800);
    rd_chk("rst_mtvec", 12'h305, 32'h0);

    // Illegal instruction with direct mtvec.
    csr_op(2'b01, 12'h305, 32'h100);
    csr_op(2'b01, 12'h341, 32'h55);
    rd_chk("mepc_lowbits", 12'h341, 32'h54);
    clear_in(); illegal_inst = 1; inst_word = 32'hFFFF_FFFF; epc_cur = 32'h40; tick();
    chk("ill_pc", last_pc, 32'h100);
    chk("ill_cancel", 32'(last_cancel), 32'h1);
    rd_chk("ill_mepc", 12'h341, 32'h40);
    rd_chk("ill_mcause", 12'h342, 32'h2);
    rd_chk("ill_mtval", 12'h343, 32'hFFFF_FFFF);
    rd_chk("ill_mstatus", 12'h300, 32'h1800);

    // Vectored interrupts, lowest index first.
    csr_op(2'b01, 12'h300, 32'h8);
    csr_op(2'b01, 12'h304, 32'h5_0000);
    csr_op(2'b01, 12'h305, 32'h201);
    rd_chk("mtvec_warl", 12'h305, 32'h201);
    clear_in(); irq = 4'b0101; tick();
    chk("irq_sample_no_trap", 32'(last_valid), 32'h0);
    clear_in(); tick();
    chk("irq0_pc", last_pc, 32'h240);
    irq = 4'b0100;
    rd_chk("irq0_mcause", 12'h342, 32'h8000_0010);
    do_mret();
    clear_in(); tick();
    chk("settle_masks_irq", 32'(last_valid), 32'h0);
    clear_in(); tick();
    chk("irq2_pc", last_pc, 32'h248);
    rd_chk("irq2_mcause", 12'h342, 32'h8000_0012);

    // Exception beats a pending enabled interrupt.
    do_mret();
    clear_in(); tick();
    clear_in(); ecall_m = 1; l_access_fault = 1; fault_addr = 32'hABCD; epc_cur = 32'h60; tick();
    chk("ecall_pc", last_pc, 32'h200);
    rd_chk("ecall_mcause", 12'h342, 32'd11);
    rd_chk("ecall_mtval", 12'h343, 32'h0);
    clear_in(); tick();
    chk("mie0_no_irq", 32'(last_valid), 32'h0);
    do_mret();
    clear_in(); tick();
    clear_in(); tick();
    chk("irq_after_mret", last_pc, 32'h248);

    // CSR set suppressed by a store fault in the same cycle.
    clear_in(); tick();
    clear_in(); csr_rw = 1; csr_wsc_mode = 2'b10; csr_addr = 12'h300; csr_wdata = 32'h8;
    s_access_fault = 1; fault_addr = 32'h1234; tick();
    rd_chk("sf_mstatus", 12'h300, 32'h1800);
    rd_chk("sf_mcause", 12'h342, 32'd7);
    rd_chk("sf_mtval", 12'h343, 32'h1234);

    // mret restores MIE, SETTLE defers the pending interrupt.
    csr_op(2'b01, 12'h341, 32'h80);
    csr_op(2'b01, 12'h300, 32'h80);
    do_mret();
    chk("mret_pc", last_pc, 32'h80);
    chk("mret_cancel", 32'(last_cancel), 32'h0);
    rd_chk("mret_mstatus", 12'h300, 32'h1888);
    chk("mret_settle_no_irq", 32'(last_valid), 32'h0);
    clear_in(); tick();
    chk("mret_then_irq", 32'(last_valid), 32'h1);

    // Reset overrides a same-cycle trap and CSR write.
    irq = '0;
    clear_in(); tick();
    clear_in(); rst = 1; illegal_inst = 1; csr_rw = 1; csr_wsc_mode = 2'b01;
    csr_addr = 12'h340; csr_wdata = 32'hDEAD; tick();
    chk("rst_trap_valid", 32'(last_valid), 32'h0);
    rd_chk("rst_trap_mstatus", 12'h300, 32'h1800);
    rd_chk("rst_trap_mscratch", 12'h340, 32'h0);
    rd_chk("rst_trap_mcause", 12'h342, 32'h0);

    // Randomised traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      clear_in();
      rst = ($urandom_range(99) == 0);
      csr_addr = addrs[$urandom_range(8)];
      csr_rw = ($urandom_range(2) == 0);
      csr_wsc_mode = 2'($urandom);
      csr_wdata = ($urandom_range(1) == 0) ? $urandom : (32'h8 | (32'($urandom_range(15)) << 16) | 32'h1);
      if ($urandom_range(3) == 0) irq = NIRQ'($urandom);
      illegal_inst   = ($urandom_range(15) == 0);
      ecall_m        = ($urandom_range(15) == 0);
      l_access_fault = ($urandom_range(15) == 0);
      s_access_fault = ($urandom_range(15) == 0);
      inst_word = $urandom; fault_addr = $urandom; epc_cur = $urandom; epc_next = epc_cur + 4;
      mret = ($urandom_range(9) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
